store_queue: RTL and testbench

- Circular store queue between dispatch, the memory functional unit, retire and the dcache.
- Allocates one entry per dispatched store, in program order.
- Captures address and data when the memory FU executes the store.
- Answers store-to-load forwarding lookups in the same cycle, and drains retired stores to the dcache in order.
- Acts as the responder for the FU's lookup interface and the receiver of its store-queue fill entry.

---
 rtl/store_queue_pkg.sv | 33 +++
 rtl/sq_forward_search.sv | 40 ++++
 rtl/store_queue.sv | 100 ++++++++++
 tb/tb_store_queue.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: depth, index width, the FU fill record
// and the per-entry storage record.
package store_queue_pkg;

    localparam int SQ_DEPTH = 8;
    localparam int SQ_IDX_W = $clog2(SQ_DEPTH);
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    typedef logic [SQ_IDX_W-1:0] STOREQ_IDX;
    typedef logic [ADDR_W-1:0]   ADDR;
    typedef logic [DATA_W-1:0]   DATA;

    typedef struct packed {
        logic      valid;
        ADDR       addr;
        DATA       data;
        STOREQ_IDX store_queue_idx;
    } EXECUTE_STOREQ_ENTRY;

    typedef struct packed {
        logic filled;
        logic committed;
        ADDR  addr;
        DATA  data;
    } STOREQ_ENTRY;

    // Circular distance from 'from' to 'to'; wraps for free since depth is a power of two.
    function automatic STOREQ_IDX sq_dist(input STOREQ_IDX from, input STOREQ_IDX to);
        return to - from;
    endfunction

endpackage

// File: rtl/sq_forward_search.sv
// Age-ordered store-to-load forwarding match over [head, lookup_tail).
// Walks oldest to youngest so the last hit (closest to lookup_tail) wins.
module sq_forward_search
    import store_queue_pkg::*;
(
    input  STOREQ_ENTRY entries [SQ_DEPTH],
    input  STOREQ_IDX   head,
    input  STOREQ_IDX   lookup_tail,
    input  ADDR         lookup_addr,
    output logic        hit,
    output DATA         data
);

    STOREQ_IDX span;
    STOREQ_IDX idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        span = sq_dist(head, lookup_tail);
        for (int k = 0; k < SQ_DEPTH; k++) begin
            idx = head + STOREQ_IDX'(k);
            if ((STOREQ_IDX'(k) < span) && entries[idx].filled &&
                (entries[idx].addr[ADDR_W-1:2] == lookup_addr[ADDR_W-1:2])) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

    // Word-granular match: byte offsets and commit state play no part here.
    logic [SQ_DEPTH-1:0] unused_entry_bits;
    logic                unused_lookup_lo;
    for (genvar g = 0; g < SQ_DEPTH; g++) begin : g_unused
        assign unused_entry_bits[g] = entries[g].committed ^ (^entries[g].addr[1:0]);
    end
    assign unused_lookup_lo = ^lookup_addr[1:0];

endmodule

// File: rtl/store_queue.sv
// Circular store queue: in-order allocate, out-of-order fill, zero-latency
// forwarding, in-order commit and drain to the dcache.
module store_queue
    import store_queue_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                dispatch_valid,
    output STOREQ_IDX           dispatch_idx,
    output logic                sq_full,
    output logic                sq_empty,
    input  EXECUTE_STOREQ_ENTRY store_queue_entry,
    input  logic                lookup_valid,
    input  ADDR                 lookup_addr,
    input  STOREQ_IDX           lookup_sq_tail,
    output logic                forward_valid,
    output DATA                 forward_data,
    output logic                forward_stall,
    input  logic                retire_valid,
    input  logic                flush,
    output logic                dcache_store_valid,
    output ADDR                 dcache_store_addr,
    output DATA                 dcache_store_data,
    input  logic                dcache_store_accept
);

    STOREQ_IDX   head, commit_ptr, tail;
    STOREQ_IDX   count, commit_next;
    STOREQ_ENTRY entries [SQ_DEPTH];
    logic        do_dispatch, do_retire, do_drain, fill_ok;
    logic        search_hit;
    DATA         search_data;

    assign count        = tail - head;
    assign sq_full      = (count == STOREQ_IDX'(SQ_DEPTH-1));
    assign sq_empty     = (count == '0);
    assign dispatch_idx = tail;

    assign dcache_store_valid = (head != commit_ptr);
    assign dcache_store_addr  = entries[head].addr;
    assign dcache_store_data  = entries[head].data;
    assign forward_stall      = 1'b0;

    assign do_dispatch = dispatch_valid && !sq_full && !flush;
    assign do_retire   = retire_valid && (commit_ptr != tail);
    assign do_drain    = dcache_store_accept && dcache_store_valid;
    assign commit_next = commit_ptr + STOREQ_IDX'(do_retire);

    // Fills outside the uncommitted window belong to squashed or already-retired stores.
    assign fill_ok = store_queue_entry.valid && !flush &&
                     (sq_dist(commit_ptr, store_queue_entry.store_queue_idx) < sq_dist(commit_ptr, tail));

    sq_forward_search u_search (
        .entries     (entries),
        .head        (head),
        .lookup_tail (lookup_sq_tail),
        .lookup_addr (lookup_addr),
        .hit         (search_hit),
        .data        (search_data)
    );

    assign forward_valid = lookup_valid && search_hit;
    assign forward_data  = forward_valid ? search_data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            head       <= '0;
            commit_ptr <= '0;
            tail       <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            commit_ptr <= commit_next;
            tail       <= flush ? commit_next : tail + STOREQ_IDX'(do_dispatch);
            if (do_drain) begin
                head <= head + STOREQ_IDX'(1);
            end
            if (do_dispatch) begin
                entries[tail] <= '0;
            end
            if (do_retire) begin
                entries[commit_ptr].committed <= 1'b1;
            end
            if (fill_ok) begin
                entries[store_queue_entry.store_queue_idx].filled <= 1'b1;
                entries[store_queue_entry.store_queue_idx].addr   <= store_queue_entry.addr;
                entries[store_queue_entry.store_queue_idx].data   <= store_queue_entry.data;
            end
        end
    end

    // Retiring past the tail or retiring a store that never executed is a pipeline bug.
    always_ff @(posedge clock) begin
        if (!reset && retire_valid) begin
            assert ((commit_ptr != tail) && entries[commit_ptr].filled);
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: a program-order queue model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_store_queue;
    import store_queue_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic                dispatch_valid;
    STOREQ_IDX           dispatch_idx;
    logic                sq_full, sq_empty;
    EXECUTE_STOREQ_ENTRY sq_fill;
    logic                lookup_valid;
    ADDR                 lookup_addr;
    STOREQ_IDX           lookup_sq_tail;
    logic                forward_valid;
    DATA                 forward_data;
    logic                forward_stall;
    logic                retire_valid, flush;
    logic                dcache_store_valid;
    ADDR                 dcache_store_addr;
    DATA                 dcache_store_data;
    logic                dcache_store_accept;

    int checks = 0;
    int errors = 0;

    store_queue dut (
        .clock               (clock),
        .reset               (reset),
        .dispatch_valid      (dispatch_valid),
        .dispatch_idx        (dispatch_idx),
        .sq_full             (sq_full),
        .sq_empty            (sq_empty),
        .store_queue_entry   (sq_fill),
        .lookup_valid        (lookup_valid),
        .lookup_addr         (lookup_addr),
        .lookup_sq_tail      (lookup_sq_tail),
        .forward_valid       (forward_valid),
        .forward_data        (forward_data),
        .forward_stall       (forward_stall),
        .retire_valid        (retire_valid),
        .flush               (flush),
        .dcache_store_valid  (dcache_store_valid),
        .dcache_store_addr   (dcache_store_addr),
        .dcache_store_data   (dcache_store_data),
        .dcache_store_accept (dcache_store_accept)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stores in program order from head; the first mnc are committed.
    typedef struct {
        bit          filled;
        logic [31:0] addr;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      mq[$];
    int          mh = 0;
    int          mnc = 0;
    bit          mvalid = 0;
    int          sz0, nc0, span, pos;
    bit          m_hit;
    logic [31:0] m_data;

    always @(negedge clock) begin
        if (mvalid) begin
            sz0 = mq.size();
            chk("dispatch_idx", 32'(dispatch_idx), 32'((mh + sz0) % SQ_DEPTH));
            chk("sq_full", 32'(sq_full), 32'(sz0 == SQ_DEPTH - 1));
            chk("sq_empty", 32'(sq_empty), 32'(sz0 == 0));
            chk("forward_stall", 32'(forward_stall), 32'h0);
            span   = (int'(lookup_sq_tail) - mh + SQ_DEPTH) % SQ_DEPTH;
            m_hit  = 0;
            m_data = 32'h0;
            for (int p = 0; p < span && p < sz0; p++) begin
                if (mq[p].filled && (mq[p].addr[31:2] == lookup_addr[31:2])) begin
                    m_hit  = 1;
                    m_data = mq[p].data;
                end
            end
            chk("forward_valid", 32'(forward_valid), 32'(lookup_valid && m_hit));
            chk("forward_data", forward_data, (lookup_valid && m_hit) ? m_data : 32'h0);
            chk("dcache_store_valid", 32'(dcache_store_valid), 32'(mnc > 0));
            if (mnc > 0) begin
                chk("dcache_store_addr", dcache_store_addr, mq[0].addr);
                chk("dcache_store_data", dcache_store_data, mq[0].data);
            end
        end
        if (reset) begin
            mq.delete();
            mh     = 0;
            mnc    = 0;
            mvalid = 1;
        end else if (mvalid) begin
            sz0 = mq.size();
            nc0 = mnc;
            if (sq_fill.valid && !flush) begin
                pos = (int'(sq_fill.store_queue_idx) - mh + SQ_DEPTH) % SQ_DEPTH;
                if (pos >= nc0 && pos < sz0) begin
                    mq[pos].filled = 1;
                    mq[pos].addr   = sq_fill.addr;
                    mq[pos].data   = sq_fill.data;
                end
            end
            if (retire_valid && mnc < sz0) mnc++;
            if (flush) begin
                while (mq.size() > mnc) void'(mq.pop_back());
            end else if (dispatch_valid && sz0 < SQ_DEPTH - 1) begin
                mq.push_back('{filled: 1'b0, addr: 32'h0, data: 32'h0});
            end
            if (dcache_store_accept && nc0 > 0) begin
                void'(mq.pop_front());
                mh = (mh + 1) % SQ_DEPTH;
                mnc--;
            end
        end
    end

    task automatic clr();
        dispatch_valid      = 0;
        sq_fill             = '0;
        lookup_valid        = 0;
        lookup_addr         = '0;
        lookup_sq_tail      = '0;
        retire_valid        = 0;
        flush               = 0;
        dcache_store_accept = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clr();
    endtask

    task automatic fill(input int idx, input logic [31:0] a, input logic [31:0] d);
        sq_fill.valid           = 1;
        sq_fill.store_queue_idx = STOREQ_IDX'(idx);
        sq_fill.addr            = a;
        sq_fill.data            = d;
        tick();
    endtask

    task automatic look(input logic [31:0] a, input int t);
        lookup_valid   = 1;
        lookup_addr    = a;
        lookup_sq_tail = STOREQ_IDX'(t);
        #1;
    endtask

    task automatic dispatch_n(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            dispatch_valid = 1;
            #1;
            chk("dispatch_idx_alloc", 32'(dispatch_idx), 32'((first + i) % SQ_DEPTH));
            tick();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_sq_empty", 32'(sq_empty), 32'h1);
        chk("rst_sq_full", 32'(sq_full), 32'h0);
        chk("rst_dispatch_idx", 32'(dispatch_idx), 32'h0);
        chk("rst_dc_valid", 32'(dcache_store_valid), 32'h0);
        chk("rst_dc_addr", dcache_store_addr, 32'h0);
        chk("rst_dc_data", dcache_store_data, 32'h0);
        chk("rst_fwd_valid", 32'(forward_valid), 32'h0);
        chk("rst_fwd_data", forward_data, 32'h0);
    endtask

    logic [31:0] wrap_addr [7] = '{32'h200, 32'h204, 32'h208, 32'h300, 32'h304, 32'h300, 32'h300};
    logic [31:0] wrap_data [7] = '{32'h1000, 32'h1001, 32'h1002, 32'h3333, 32'h4444, 32'h5555, 32'h6666};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        reset = 1;
        tick();
        tick();
        reset = 0;
        chk_reset_outputs();

        // Fill and forward
        dispatch_n(3, 0);
        fill(0, 32'h100, 32'hAAAA);
        fill(2, 32'h100, 32'hBBBB);
        look(32'h100, 3);
        chk("fwd_young_valid", 32'(forward_valid), 32'h1);
        chk("fwd_young_data", forward_data, 32'hBBBB);
        look(32'h100, 2);
        chk("fwd_old_data", forward_data, 32'hAAAA);
        look(32'h104, 3);
        chk("skip_unfilled_valid", 32'(forward_valid), 32'h0);
        chk("skip_unfilled_data", forward_data, 32'h0);
        look(32'h102, 3);
        chk("fwd_word_match", forward_data, 32'hBBBB);
        tick();
        fill(1, 32'h104, 32'hCCCC);
        look(32'h104, 3);
        chk("fwd_after_fill", forward_data, 32'hCCCC);
        tick();

        // Commit and drain with backpressure
        retire_valid = 1;
        tick();
        retire_valid = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("drain_hold_valid", 32'(dcache_store_valid), 32'h1);
            chk("drain_hold_addr", dcache_store_addr, 32'h100);
            chk("drain_hold_data", dcache_store_data, 32'hAAAA);
            if (k < 2) tick();
        end
        dcache_store_accept = 1;
        tick();
        chk("drain_next_addr", dcache_store_addr, 32'h104);
        chk("drain_next_data", dcache_store_data, 32'hCCCC);
        dcache_store_accept = 1;
        tick();
        chk("drain_done_valid", 32'(dcache_store_valid), 32'h0);
        chk("drain_not_empty", 32'(sq_empty), 32'h0);

        // Full and wrap-around
        reset = 1;
        tick();
        reset = 0;
        dispatch_n(7, 0);
        chk("full_set", 32'(sq_full), 32'h1);
        dispatch_valid = 1;
        tick();
        chk("full_ignored_idx", 32'(dispatch_idx), 32'h7);
        for (int i = 0; i < 7; i++) fill(i, wrap_addr[i], wrap_data[i]);
        for (int i = 0; i < 3; i++) begin
            retire_valid = 1;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            dcache_store_accept = 1;
            tick();
        end
        chk("unfull_after_drain", 32'(sq_full), 32'h0);
        dispatch_n(3, 7);
        chk("wrap_tail", 32'(dispatch_idx), 32'h2);
        chk("wrap_full", 32'(sq_full), 32'h1);
        fill(0, 32'h300, 32'h0A0A);
        look(32'h300, 1);
        chk("wrap_fwd_youngest", forward_data, 32'h0A0A);
        look(32'h300, 7);
        chk("wrap_fwd_tail7", forward_data, 32'h6666);
        look(32'h304, 1);
        chk("wrap_fwd_mid", forward_data, 32'h4444);
        look(32'h200, 1);
        chk("wrap_no_stale", 32'(forward_valid), 32'h0);
        tick();

        // Flush with same-cycle retire
        reset = 1;
        tick();
        reset = 0;
        dispatch_n(5, 0);
        for (int i = 0; i < 5; i++) fill(i, 32'h400 + 32'(4 * i), 32'h40 + 32'(i));
        retire_valid = 1;
        tick();
        retire_valid = 1;
        tick();
        flush          = 1;
        retire_valid   = 1;
        dispatch_valid = 1;
        sq_fill        = '{valid: 1'b1, addr: 32'h400, data: 32'hDEAD, store_queue_idx: 3'd4};
        tick();
        chk("flush_tail", 32'(dispatch_idx), 32'h3);
        chk("flush_dc_valid", 32'(dcache_store_valid), 32'h1);
        chk("flush_dc_addr", dcache_store_addr, 32'h400);
        fill(4, 32'h400, 32'hDEAD);
        look(32'h400, 3);
        chk("flush_fwd_data", forward_data, 32'h40);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("flush_drain_addr", dcache_store_addr, 32'h400 + 32'(4 * k));
            dcache_store_accept = 1;
            tick();
        end
        chk("flush_drained", 32'(sq_empty), 32'h1);

        // Reset mid-drain
        dispatch_n(2, 3);
        fill(3, 32'h500, 32'h77);
        retire_valid = 1;
        tick();
        chk("pre_reset_valid", 32'(dcache_store_valid), 32'h1);
        reset = 1;
        tick();
        chk_reset_outputs();
        reset = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
